fetch_pc_ctrl: RTL and testbench

- Program-counter register and next-PC selector for the SEQ-style Y86-64 core.
- Drives the PC into the instruction memory and consumes the decoded icode/ifun/valC it returns.
- Computes valP and selects the next PC from valP, the branch/call target, or the return address.
- Holds the processor status state machine (AOK/HLT/ADR/INS), which freezes fetch on any fault.

---
 rtl/fetch_pc_ctrl_pkg.sv | 31 +++
 rtl/fetch_pc_ctrl_ins_length.sv | 34 +++
 rtl/fetch_pc_ctrl.sv | 96 +++++++++
 tb/tb_fetch_pc_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared Y86-64 fetch constants: icode values, status codes and ifun limits.
package fetch_pc_ctrl_pkg;

    localparam int unsigned ICODE_WID = 4;
    localparam int unsigned LEN_WID   = 4;
    localparam int unsigned CNT_WID   = 32;

    typedef enum logic [1:0] {
        S_AOK = 2'd0,
        S_HLT = 2'd1,
        S_ADR = 2'd2,
        S_INS = 2'd3
    } stat_e;

    localparam logic [ICODE_WID-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_WID-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_WID-1:0] I_CMOVXX = 4'h2;
    localparam logic [ICODE_WID-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_WID-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_WID-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_WID-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_WID-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_WID-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_WID-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_WID-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_WID-1:0] I_POPQ   = 4'hB;

    localparam logic [ICODE_WID-1:0] IFUN_MAX_CMOV_JXX = 4'd6;
    localparam logic [ICODE_WID-1:0] IFUN_MAX_OPQ      = 4'd3;

endpackage

// File: rtl/fetch_pc_ctrl_ins_length.sv
// Combinational instruction length and icode/ifun legality check.
module fetch_pc_ctrl_ins_length
    import fetch_pc_ctrl_pkg::*;
(
    input  logic [ICODE_WID-1:0] icode,
    input  logic [ICODE_WID-1:0] ifun,
    output logic [LEN_WID-1:0]   len_c,
    output logic                 ins_bad_c
);

    always_comb begin
        len_c = LEN_WID'(1);
        case (icode)
            I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: len_c = LEN_WID'(2);
            I_JXX, I_CALL:                    len_c = LEN_WID'(9);
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     len_c = LEN_WID'(10);
            default:                          len_c = LEN_WID'(1);
        endcase
    end

    always_comb begin
        ins_bad_c = 1'b0;
        if (icode > I_POPQ) begin
            ins_bad_c = 1'b1;
        end else begin
            case (icode)
                I_CMOVXX, I_JXX: ins_bad_c = (ifun > IFUN_MAX_CMOV_JXX);
                I_OPQ:           ins_bad_c = (ifun > IFUN_MAX_OPQ);
                default:         ins_bad_c = (ifun != '0);
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// SEQ Y86-64 program counter, next-PC select and sticky processor status FSM.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned          DATA_WID  = 64,
    parameter int unsigned          MEM_BYTES = 2048,
    parameter logic [DATA_WID-1:0]  RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           icode_i,
    input  logic [3:0]           ifun_i,
    input  logic [DATA_WID-1:0]  valC_i,
    input  logic [DATA_WID-1:0]  valM_i,
    input  logic                 cnd_i,
    input  logic                 stall_i,
    output logic [DATA_WID-1:0]  pc_o,
    output logic [DATA_WID-1:0]  valP_o,
    output logic [1:0]           stat_o,
    output logic [31:0]          instr_cnt_o
);

    localparam logic [DATA_WID:0] MEM_LIMIT = (DATA_WID+1)'(MEM_BYTES);

    stat_e               stat_q, stat_d;
    logic [DATA_WID-1:0] pc_q, pc_d, next_pc;
    logic [CNT_WID-1:0]  cnt_q, cnt_d;
    logic [LEN_WID-1:0]  len;
    logic                ins_bad;
    logic [DATA_WID:0]   pc_sum;
    logic                adr_fault;

    fetch_pc_ctrl_ins_length u_ins_length (
        .icode     (icode_i),
        .ifun      (ifun_i),
        .len_c     (len),
        .ins_bad_c (ins_bad)
    );

    // Extra sum bit keeps the carry so a PC near 2^DATA_WID still faults.
    assign pc_sum    = {1'b0, pc_q} + (DATA_WID+1)'(len);
    assign adr_fault = (pc_sum > MEM_LIMIT);
    assign valP_o    = pc_sum[DATA_WID-1:0];

    always_comb begin
        next_pc = valP_o;
        case (icode_i)
            I_CALL:  next_pc = valC_i;
            I_JXX:   next_pc = ((ifun_i == '0) || cnd_i) ? valC_i : valP_o;
            I_RET:   next_pc = valM_i;
            default: next_pc = valP_o;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= S_AOK;
            pc_q   <= RESET_PC;
            cnt_q  <= '0;
        end else begin
            stat_q <= stat_d;
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
        end
    end

    // Only AOK advances; HLT/ADR/INS freeze everything until reset.
    always_comb begin
        stat_d = stat_q;
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        case (stat_q)
            S_AOK: begin
                if (!stall_i) begin
                    if (adr_fault) begin
                        stat_d = S_ADR;
                    end else if (ins_bad) begin
                        stat_d = S_INS;
                    end else if (icode_i == I_HALT) begin
                        stat_d = S_HLT;
                        cnt_d  = cnt_q + CNT_WID'(1);
                    end else begin
                        pc_d  = next_pc;
                        cnt_d = cnt_q + CNT_WID'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign pc_o        = pc_q;
    assign stat_o      = stat_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with hand-computed expectations.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  icode_i;
    logic [3:0]  ifun_i;
    logic [63:0] valC_i;
    logic [63:0] valM_i;
    logic        cnd_i;
    logic        stall_i;
    logic [63:0] pc_o;
    logic [63:0] valP_o;
    logic [1:0]  stat_o;
    logic [31:0] instr_cnt_o;

    int checks = 0;
    int errors = 0;

    fetch_pc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .icode_i     (icode_i),
        .ifun_i      (ifun_i),
        .valC_i      (valC_i),
        .valM_i      (valM_i),
        .cnd_i       (cnd_i),
        .stall_i     (stall_i),
        .pc_o        (pc_o),
        .valP_o      (valP_o),
        .stat_o      (stat_o),
        .instr_cnt_o (instr_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                        input logic [63:0] vm, input logic c, input logic st);
        icode_i = ic; ifun_i = fn; valC_i = vc; valM_i = vm; cnd_i = c; stall_i = st;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'h1, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc_o !== 64'h0) begin errors++; $display("FAIL reset_pc got %0h exp 0", pc_o); end
        checks++; if (stat_o !== 2'd0) begin errors++; $display("FAIL reset_stat got %0d exp 0", stat_o); end
        checks++; if (instr_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", instr_cnt_o); end
    endtask

    task automatic test_sequential();
        do_reset();
        step(4'h1, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'd1) begin errors++; $display("FAIL seq_nop got %0h exp 1", pc_o); end
        icode_i = 4'h3; #1;
        checks++; if (valP_o !== 64'd11) begin errors++; $display("FAIL seq_valp got %0d exp 11", valP_o); end
        step(4'h3, 4'h0, 64'h5, 64'h0, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'd11) begin errors++; $display("FAIL seq_irmovq got %0d exp 11", pc_o); end
        step(4'h6, 4'h3, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'd13) begin errors++; $display("FAIL seq_opq got %0d exp 13", pc_o); end
        checks++; if (instr_cnt_o !== 32'd3) begin errors++; $display("FAIL seq_cnt got %0d exp 3", instr_cnt_o); end
        checks++; if (stat_o !== 2'd0) begin errors++; $display("FAIL seq_stat got %0d exp 0", stat_o); end
    endtask

    task automatic test_jump();
        do_reset();
        step(4'h7, 4'h0, 64'h20, 64'h0, 1'b0, 1'b0);
        step(4'h7, 4'h1, 64'h100, 64'h0, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'h29) begin errors++; $display("FAIL jxx_not_taken got %0h exp 29", pc_o); end
        step(4'h7, 4'h0, 64'h20, 64'h0, 1'b0, 1'b0);
        step(4'h7, 4'h1, 64'h100, 64'h0, 1'b1, 1'b0);
        checks++; if (pc_o !== 64'h100) begin errors++; $display("FAIL jxx_taken got %0h exp 100", pc_o); end
        checks++; if (instr_cnt_o !== 32'd4) begin errors++; $display("FAIL jxx_cnt got %0d exp 4", instr_cnt_o); end
    endtask

    task automatic test_call_ret();
        do_reset();
        step(4'h7, 4'h0, 64'h40, 64'h0, 1'b0, 1'b0);
        step(4'h8, 4'h0, 64'h80, 64'h0, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'h80) begin errors++; $display("FAIL call_pc got %0h exp 80", pc_o); end
        step(4'h9, 4'h0, 64'h0, 64'h49, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'h49) begin errors++; $display("FAIL ret_pc got %0h exp 49", pc_o); end
    endtask

    task automatic test_halt();
        do_reset();
        step(4'h7, 4'h0, 64'h10, 64'h0, 1'b0, 1'b0);
        step(4'h0, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (stat_o !== 2'd1) begin errors++; $display("FAIL halt_stat got %0d exp 1", stat_o); end
        checks++; if (pc_o !== 64'h10) begin errors++; $display("FAIL halt_pc got %0h exp 10", pc_o); end
        checks++; if (instr_cnt_o !== 32'd2) begin errors++; $display("FAIL halt_cnt got %0d exp 2", instr_cnt_o); end
        step(4'h1, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        step(4'h7, 4'h0, 64'h300, 64'h0, 1'b1, 1'b0);
        checks++; if (pc_o !== 64'h10 || stat_o !== 2'd1 || instr_cnt_o !== 32'd2) begin
            errors++; $display("FAIL halt_sticky got pc %0h stat %0d cnt %0d exp 10 1 2", pc_o, stat_o, instr_cnt_o);
        end
        do_reset();
        checks++; if (pc_o !== 64'h0 || stat_o !== 2'd0 || instr_cnt_o !== 32'd0) begin
            errors++; $display("FAIL halt_reset got pc %0h stat %0d cnt %0d exp 0 0 0", pc_o, stat_o, instr_cnt_o);
        end
    endtask

    task automatic test_adr();
        do_reset();
        step(4'h7, 4'h0, 64'd2040, 64'h0, 1'b0, 1'b0);
        step(4'h3, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (stat_o !== 2'd2) begin errors++; $display("FAIL adr_stat got %0d exp 2", stat_o); end
        checks++; if (pc_o !== 64'd2040) begin errors++; $display("FAIL adr_pc got %0d exp 2040", pc_o); end
        checks++; if (instr_cnt_o !== 32'd1) begin errors++; $display("FAIL adr_cnt got %0d exp 1", instr_cnt_o); end
        // Last legal byte, then a target exactly at the end of memory.
        do_reset();
        step(4'h7, 4'h0, 64'd2047, 64'h0, 1'b0, 1'b0);
        step(4'h1, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'd2048 || stat_o !== 2'd0) begin
            errors++; $display("FAIL adr_edge got pc %0d stat %0d exp 2048 0", pc_o, stat_o);
        end
        step(4'hC, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (stat_o !== 2'd2 || pc_o !== 64'd2048) begin
            errors++; $display("FAIL adr_over_ins got pc %0d stat %0d exp 2048 2", pc_o, stat_o);
        end
    endtask

    task automatic test_ins();
        do_reset();
        step(4'h1, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        step(4'hC, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (stat_o !== 2'd3 || pc_o !== 64'd1) begin
            errors++; $display("FAIL ins_icode got pc %0d stat %0d exp 1 3", pc_o, stat_o);
        end
        do_reset();
        step(4'h6, 4'h4, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (stat_o !== 2'd3) begin errors++; $display("FAIL ins_opq_ifun got %0d exp 3", stat_o); end
        do_reset();
        step(4'h2, 4'h6, 64'h0, 64'h0, 1'b0, 1'b0);
        step(4'h7, 4'h7, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (stat_o !== 2'd3 || pc_o !== 64'd2) begin
            errors++; $display("FAIL ins_jxx_ifun got pc %0d stat %0d exp 2 3", pc_o, stat_o);
        end
        do_reset();
        step(4'h1, 4'h1, 64'h0, 64'h0, 1'b0, 1'b0);
        checks++; if (stat_o !== 2'd3) begin errors++; $display("FAIL ins_nop_ifun got %0d exp 3", stat_o); end
    endtask

    task automatic test_stall();
        do_reset();
        step(4'h7, 4'h0, 64'h40, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'h8, 4'h0, 64'h80, 64'h0, 1'b0, 1'b1);
            checks++; if (pc_o !== 64'h40 || instr_cnt_o !== 32'd1) begin
                errors++; $display("FAIL stall_hold%0d got pc %0h cnt %0d exp 40 1", i, pc_o, instr_cnt_o);
            end
        end
        step(4'h8, 4'h0, 64'h80, 64'h0, 1'b0, 1'b0);
        checks++; if (pc_o !== 64'h80 || instr_cnt_o !== 32'd2) begin
            errors++; $display("FAIL stall_release got pc %0h cnt %0d exp 80 2", pc_o, instr_cnt_o);
        end
    endtask

    task automatic test_rst_priority();
        do_reset();
        step(4'h7, 4'h0, 64'h30, 64'h0, 1'b0, 1'b0);
        step(4'hD, 4'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step(4'hD, 4'h0, 64'h0, 64'h0, 1'b0, 1'b1);
        rst = 1'b0;
        checks++; if (pc_o !== 64'h0 || stat_o !== 2'd0 || instr_cnt_o !== 32'd0) begin
            errors++; $display("FAIL rst_priority got pc %0h stat %0d cnt %0d exp 0 0 0", pc_o, stat_o, instr_cnt_o);
        end
    endtask

    initial begin
        rst = 1'b1; icode_i = 4'h1; ifun_i = 4'h0; valC_i = '0; valM_i = '0; cnd_i = 1'b0; stall_i = 1'b0;
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_halt();
        test_adr();
        test_ins();
        test_stall();
        test_rst_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
